// File: rtl/hbram_arbiter_if.sv
// hbram_arbiter_if: requester-side and HyperRAM-controller-side signals of hbram_arbiter.
interface hbram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 24
);
    logic                          hbc_cal_pass;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_rdwr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic                          ram_idle;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic                          err;
    logic                          ram_en;
    logic [31:0]                   ram_addr;
    logic                          ram_rdwr;
    logic                          busy;
    modport master (
        input  hbc_cal_pass, req, req_rdwr, req_addr, ram_idle,
        output gnt, done, err, ram_en, ram_addr, ram_rdwr, busy
    );
    modport slave (
        output hbc_cal_pass, req, req_rdwr, req_addr, ram_idle,
        input  gnt, done, err, ram_en, ram_addr, ram_rdwr, busy
    );
endinterface

// File: rtl/hbram_arbiter.sv
// hbram_arbiter: round-robin sharing of one HyperRAM command port between NUM_REQ requesters.
// Define HBRAM_ARB_TIMEOUT_EN to abort a command whose ram_idle does not fall within TIMEOUT_CYCLES.
module hbram_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             clock,
    input logic             reset,
    hbram_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [2:0] INIT = 3'd0, ARB = 3'd1, ISSUE = 3'd2, BUSY = 3'd3, WAIT = 3'd4, DONE = 3'd5;
    logic [2:0]            state;
    logic [IW-1:0]         ptr, owner, sel, next_ptr;
    logic [NUM_REQ-1:0]    owner_hot;
    logic [ADDR_WIDTH-1:0] addr_l;
    logic                  rdwr_l;
    logic                  timeout;
    // Walk downwards so the last hit is the first set request at or after ptr.
    always_comb begin
        sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[(int'(ptr) + k) % NUM_REQ]) sel = IW'((int'(ptr) + k) % NUM_REQ);
    end
    assign owner_hot = NUM_REQ'(1) << owner;
    assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`ifdef HBRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bus.err <= 1'b0;
        end else begin
            cnt     <= (state == BUSY) ? cnt + 1'b1 : '0;
            bus.err <= (state == BUSY) && bus.ram_idle && timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            ptr          <= '0;
            owner        <= '0;
            addr_l       <= '0;
            rdwr_l       <= 1'b0;
            bus.gnt      <= '0;
            bus.done     <= '0;
            bus.ram_en   <= 1'b0;
            bus.ram_addr <= 32'h8000_0000;
            bus.ram_rdwr <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.ram_en <= 1'b0;
            bus.done   <= '0;
            case (state)
                INIT: state <= bus.hbc_cal_pass ? ARB : INIT;
                ARB: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    if (!bus.hbc_cal_pass) state <= INIT;
                    else if (|bus.req && bus.ram_idle) begin
                        owner  <= sel;
                        addr_l <= bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        rdwr_l <= bus.req_rdwr[sel];
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ram_en   <= 1'b1;
                    bus.ram_addr <= {1'b1, 31'(addr_l)};
                    bus.ram_rdwr <= rdwr_l;
                    bus.gnt      <= owner_hot;
                    bus.busy     <= 1'b1;
                    state        <= BUSY;
                end
                BUSY:
                    if (!bus.ram_idle) state <= WAIT;
                    else if (timeout) begin
                        bus.done <= owner_hot;
                        ptr      <= next_ptr;
                        state    <= ARB;
                    end
                WAIT: if (bus.ram_idle) state <= DONE;
                DONE: begin
                    bus.done <= owner_hot;
                    ptr      <= next_ptr;
                    state    <= ARB;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_hbram_arbiter.sv
// tb_hbram_arbiter: directed checks of calibration gating, round-robin order, command fields,
// handshake timing, mid-transaction reset and (with HBRAM_ARB_TIMEOUT_EN) the timeout abort.
module tb_hbram_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic never = 1'b0;
    int tests = 0, fails = 0, cyc = 0, c0 = 0, e0 = 0;
    int en_cnt = 0, done_cnt = 0, err_cnt = 0, en_cyc = 0, err_cyc = 0, idle_rise_cyc = 0;
    logic [3:0]  err_done = '0;
    logic [3:0]  gnt_q[$], done_q[$];
    logic [31:0] addr_q[$];
    logic        rdwr_q[$];
    int          rr_own[5]   = '{0, 1, 2, 3, 0};
    logic [3:0]  exp_hot[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] exp_addr[4] = '{32'h8012_3456, 32'h801A_0001, 32'h802B_0002, 32'h803C_0003};
    logic        exp_rw[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};

    hbram_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(24)) bus ();
    hbram_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(24), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.ram_en) begin
            en_cnt++;
            en_cyc = cyc;
            gnt_q.push_back(bus.gnt);
            addr_q.push_back(bus.ram_addr);
            rdwr_q.push_back(bus.ram_rdwr);
        end
        if (bus.done != 4'b0) begin
            done_cnt++;
            done_q.push_back(bus.done);
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc  = cyc;
            err_done = bus.done;
        end
    end

    // Controller model: ram_idle falls right after ram_en and rises 5 cycles later.
    initial begin
        bus.ram_idle = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bus.ram_en && !never && !reset) begin
                bus.ram_idle = 1'b0;
                for (int k = 0; k < 5 && !reset; k++) begin
                    @(posedge clock);
                    #1;
                end
                bus.ram_idle  = 1'b1;
                idle_rise_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    function automatic int ev_cnt(input int which);
        return which == 0 ? en_cnt : which == 1 ? done_cnt : err_cnt;
    endfunction

    task automatic wait_ev(input string tag, input int which, input int n);
        int t = 0;
        while (ev_cnt(which) < n && t < 100) begin
            step(1);
            t++;
        end
        chk(tag, ev_cnt(which) >= n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.hbc_cal_pass = 1'b0;
        bus.req          = 4'b0000;
        bus.req_rdwr     = 4'b0001;
        bus.req_addr     = {24'h3C0003, 24'h2B0002, 24'h1A0001, 24'h123456};
        step(1);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_en", bus.ram_en, 0);
        chk("rst_addr", bus.ram_addr, 32'h8000_0000);
        chk("rst_rdwr", bus.ram_rdwr, 0);
        chk("rst_busy", bus.busy, 0);
        reset   = 1'b0;
        bus.req = 4'b0001;
        step(6);
        chk("no_en_uncal", en_cnt, 0);
        c0 = cyc;
        bus.hbc_cal_pass = 1'b1;
        wait_ev("wait_en1", 0, 1);
        chk("cal_latency", en_cyc - c0, 3);
        chk("t1_addr", bus.ram_addr, 32'h8012_3456);
        chk("t1_rdwr", bus.ram_rdwr, 1);
        chk("t1_gnt", bus.gnt, 4'b0001);
        chk("t1_busy", bus.busy, 1);
        wait_ev("wait_done1", 1, 1);
        chk("t1_done", bus.done, 4'b0001);
        bus.req = 4'b0000;

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        gnt_q.delete(); addr_q.delete(); rdwr_q.delete(); done_q.delete();
        bus.req_rdwr = 4'b1010;
        bus.req      = 4'b1111;
        wait_ev("wait_rr", 1, 6);
        bus.req = 4'b0000;
        step(10);
        chk("rr_en_cnt", en_cnt, 6);
        chk("rr_done_cnt", done_cnt, 6);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_gnt%0d", i), gnt_q[i], exp_hot[rr_own[i]]);
            chk($sformatf("rr_addr%0d", i), addr_q[i], exp_addr[rr_own[i]]);
            chk($sformatf("rr_rdwr%0d", i), rdwr_q[i], exp_rw[rr_own[i]]);
            chk($sformatf("rr_done%0d", i), done_q[i], exp_hot[rr_own[i]]);
        end

        bus.req_rdwr = 4'b0100;
        bus.req      = 4'b0100;
        wait_ev("wait_en7", 0, 7);
        chk("t3_gnt", bus.gnt, 4'b0100);
        chk("t3_rdwr", bus.ram_rdwr, 1);
        wait_ev("wait_done7", 1, 7);
        chk("t3_done", bus.done, 4'b0100);
        chk("t3_done_lag", cyc - idle_rise_cyc, 2);
        bus.req = 4'b0000;

        bus.req = 4'b0010;
        wait_ev("wait_en8", 0, 8);
        chk("t4_gnt", bus.gnt, 4'b0010);
        bus.req = 4'b0000;
        wait_ev("wait_done8", 1, 8);
        chk("t4_done", bus.done, 4'b0010);
        step(10);
        chk("t4_no_reissue", en_cnt, 8);
        chk("t4_done_cnt", done_cnt, 8);

        bus.req = 4'b0001;
        wait_ev("wait_en9", 0, 9);
        step(2);
        chk("t5_in_wait", bus.ram_idle, 0);
        reset   = 1'b1;
        bus.req = 4'b0000;
        #1;
        chk("t5_addr", bus.ram_addr, 32'h8000_0000);
        chk("t5_gnt", bus.gnt, 0);
        chk("t5_busy", bus.busy, 0);
        step(3);
        reset   = 1'b0;
        c0      = cyc;
        bus.req = 4'b0100;
        wait_ev("wait_en10", 0, 10);
        chk("t5_latency", en_cyc - c0, 3);
        chk("t5_no_done", done_cnt, 8);
        wait_ev("wait_done9", 1, 9);
        chk("t5_done", bus.done, 4'b0100);
        bus.req = 4'b0000;
        step(3);

`ifdef HBRAM_ARB_TIMEOUT_EN
        never   = 1'b1;
        bus.req = 4'b1001;
        wait_ev("wait_en11", 0, 11);
        e0 = en_cyc;
        chk("to_gnt", bus.gnt, 4'b1000);
        wait_ev("wait_err", 2, 1);
        never = 1'b0;
        chk("to_latency", err_cyc - e0, 16);
        chk("to_done", err_done, 4'b1000);
        wait_ev("wait_en12", 0, 12);
        chk("to_next_gnt", bus.gnt, 4'b0001);
        wait_ev("wait_done11", 1, 11);
        chk("to_next_done", bus.done, 4'b0001);
        bus.req = 4'b0000;
        step(5);
        chk("to_err_cnt", err_cnt, 1);
`else
        chk("err_cnt", err_cnt, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hbram_arbiter.md
Name: hbram_arbiter

Overview:
- Round-robin arbiter that shares one HyperRAM controller command port between NUM_REQ requesters.
- Sits between the requester-side control logic (SPI register control, DMA-style engines) and the HyperRAM controller.
- Serialises requests using the controller's ram_en / ram_idle handshake.
- Returns a per-requester grant and completion pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 24, per-requester start-address width (1..31); zero-extended into ram_addr[30:0].
- TIMEOUT_CYCLES, 1024, cycles allowed for ram_idle to fall after ram_en (used only with the optional feature).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous reset, active high.
- hbc_cal_pass  input  1  HyperRAM calibration complete.
- req  input  NUM_REQ  per-requester request level; held until the matching done pulse.
- req_rdwr  input  NUM_REQ  per-requester direction: 0 = write, 1 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ram_idle  input  1  controller status: 1 = idle, 0 = operating.
- gnt  output  NUM_REQ  one-hot grant.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- err  output  1  one-cycle timeout pulse (optional feature only; tied 0 otherwise).
- ram_en  output  1  one-cycle command strobe.
- ram_addr  output  32  command address; bit 31 always 1.
- ram_rdwr  output  1  command direction: 0 = write, 1 = read.
- busy  output  1  high from ISSUE through DONE.

Behaviour:
- Reset values: state INIT, gnt 0, done 0, err 0, ram_en 0, ram_addr 32'h8000_0000, ram_rdwr 0, busy 0, round-robin pointer 0.
- All outputs are registered.
- State INIT: stays until hbc_cal_pass = 1, then goes to ARB.
- State ARB:
  - If hbc_cal_pass = 0, go to INIT.
  - Otherwise, when any req bit is set and ram_idle = 1, select the first set req at or after the pointer (wrapping modulo NUM_REQ).
  - Latch the owner index, req_addr slice and req_rdwr bit; go to ISSUE.
  - No request, or ram_idle = 0: stay in ARB.
- State ISSUE (exactly 1 cycle):
  - ram_en = 1, ram_addr = {1'b1, zero-extended addr}, ram_rdwr = latched direction, gnt[owner] = 1, busy = 1.
  - Next state is BUSY.
- State BUSY: ram_en returns to 0; wait for ram_idle = 0, then go to WAIT.
- State WAIT: wait for ram_idle = 1, then go to DONE.
- State DONE (1 cycle):
  - done[owner] = 1.
  - gnt and busy clear on the following cycle.
  - Pointer becomes owner+1, wrapping to 0 after NUM_REQ-1.
  - Next state is ARB; a new ISSUE can occur no earlier than 2 cycles after DONE.
- Latency: req set in an idle system → ram_en 2 cycles later (one cycle in ARB, then ISSUE registers ram_en).
- ram_addr and ram_rdwr hold their values between transactions; ram_rdwr is not forced to 0 when idle.
- req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- Other req or req_addr changes after ISSUE do not affect the active command.
- hbc_cal_pass falling mid-transaction: the transaction completes, then DONE → ARB → INIT.
- ram_idle already 0 in ARB: no grant is issued.
- Simultaneous requests: strict round-robin; no requester waits longer than NUM_REQ-1 transactions.
- Reset asserted mid-operation: all outputs and the pointer return to reset values immediately (asynchronous); no done pulse is produced.

Optional Feature:
- Macro HBRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts in BUSY.
  - If ram_idle has not fallen within TIMEOUT_CYCLES cycles, err pulses 1 cycle and done[owner] pulses in the same cycle.
  - The pointer advances and the state returns to ARB.
- Not defined: no counter, err tied to 0, BUSY waits indefinitely.

Test Plan:
- hbc_cal_pass = 0 with req = 4'b0001 → no ram_en. Raise cal_pass → ram_en within 3 cycles, ram_addr = 32'h8012_3456 for req_addr[0] = 24'h123456, ram_rdwr = req_rdwr[0], gnt = 4'b0001.
- req = 4'b1111 held continuously, model controller with 5-cycle busy → grant order 0,1,2,3,0; exactly one done pulse per transaction, to the owner.
- req_rdwr[2] = 1, only req[2] set → ram_rdwr = 1 at ram_en; done = 4'b0100 one cycle after ram_idle re-rises and the state reaches DONE.
- Drop req[1] while in BUSY → transaction completes, done[1] pulses, no re-issue for requester 1.
- Assert reset during WAIT → ram_addr = 32'h8000_0000, gnt = 0, busy = 0, state INIT, no done pulse.
- With HBRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, controller never drops ram_idle → err and done[owner] pulse together 16 cycles after entering BUSY; the next requester is then served.
